// File: rtl/decode_execute_seq.sv
// decode_execute_seq: registered decode-and-execute ALU with valid/ready
// handshakes on both sides. Eight-entry opcode map over WIDTH-bit operands;
// ASR and ROL are variable-amount and run one bit position per clock under a
// two-state FSM (IDLE/SHIFT). Non-shift results appear one edge after accept.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake for rs, rt, sel
//   rs, rt                operands; rs[SHAMT_W-1:0] is the shift amount
//   sel                   opcode (0 SUB, 1 ADD, 2 OR, 3 AND, 4 ASR, 5 ROL,
//                         6 LT unsigned, 7 EQ)
//   out_valid / out_ready output handshake for rd
//   rd                    registered result
//   busy                  high while a multi-cycle shift is in progress
//
// Optional build macro DAE_FLAGS_EN adds flag_z, flag_c, flag_v, registered
// alongside rd (carry = no-borrow for SUB; carry/overflow only for ADD/SUB).
module decode_execute_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             busy
`ifdef DAE_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] N_MAX  = SHAMT_W'(WIDTH - 1);
  localparam logic [SHAMT_W-1:0] N_WRAP = SHAMT_W'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               rol_q, rol_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               is_shift;
  logic               load_imm;
  logic               shift_done;
  logic [SHAMT_W-1:0] n_raw;
  logic [SHAMT_W-1:0] n_eff;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   shift_res;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_shift  = (sel[2:1] == 2'b10);
  assign rd        = rd_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);

  // Out-of-range amounts only exist for non-power-of-2 WIDTH. Since
  // n_raw < 2^SHAMT_W < 2*WIDTH, one subtraction gives n mod WIDTH for ROL;
  // ASR saturates at WIDTH-1.
  always_comb begin
    n_raw = rs[SHAMT_W-1:0];
    if (n_raw <= N_MAX) begin
      n_eff = n_raw;
    end else if (sel[0]) begin
      n_eff = n_raw - N_WRAP;
    end else begin
      n_eff = N_MAX;
    end
  end

  always_comb begin
    alu_res = rt;
    case (sel)
      3'd0:    alu_res = rs - rt;
      3'd1:    alu_res = rs + rt;
      3'd2:    alu_res = rs | rt;
      3'd3:    alu_res = rs & rt;
      3'd4,
      3'd5:    alu_res = rt;
      3'd6:    alu_res = {{(WIDTH-1){1'b0}}, (rs < rt)};
      default: alu_res = {{(WIDTH-1){1'b0}}, (rs == rt)};
    endcase
  end

  assign shift_res = rol_q ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
                           : {work_q[WIDTH-1], work_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    rol_d       = rol_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    load_imm    = 1'b0;
    shift_done  = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (n_eff != '0)) begin
            state_d = SHIFT;
            work_d  = rt;
            cnt_d   = n_eff;
            rol_d   = sel[0];
          end else begin
            load_imm    = 1'b1;
            rd_d        = alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = shift_res;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          shift_done  = 1'b1;
          rd_d        = shift_res;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      rol_q       <= 1'b0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      rol_q       <= rol_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef DAE_FLAGS_EN
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;
  logic             add_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;

  // SUB runs through the same adder as rs + ~rt + 1, so carry = no borrow.
  always_comb begin
    add_op   = (sel[2:1] == 2'b00);
    b_op     = sel[0] ? rt : ~rt;
    sum_ext  = {1'b0, rs} + {1'b0, b_op} + {{WIDTH{1'b0}}, ~sel[0]};
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    if (load_imm) begin
      flag_z_d = (alu_res == '0);
      flag_c_d = add_op & sum_ext[WIDTH];
      flag_v_d = add_op & (rs[WIDTH-1] == b_op[WIDTH-1])
                        & (sum_ext[WIDTH-1] != rs[WIDTH-1]);
    end else if (shift_done) begin
      flag_z_d = (shift_res == '0);
      flag_c_d = 1'b0;
      flag_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  end

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
`endif

endmodule

// File: tb/tb_decode_execute_seq.sv
// Self-checking bench for decode_execute_seq: scoreboard queue filled by the
// stimulus side, drained by a negedge monitor; a WIDTH=8 instance covers the
// wide-operand cases.
module tb_decode_execute_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] rs, rt, rd;
  logic [2:0]   sel;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]   rs8, rt8, rd8;
  logic [2:0]   sel8;

`ifdef DAE_FLAGS_EN
  logic flag_z, flag_c, flag_v, fz8, fc8, fv8;
`endif

  always #5 clk = ~clk;

  decode_execute_seq #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd), .busy(busy)
`ifdef DAE_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
`endif
  );

  decode_execute_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .rs(rs8), .rt(rt8), .sel(sel8), .out_valid(out_valid8),
    .out_ready(out_ready8), .rd(rd8), .busy(busy8)
`ifdef DAE_FLAGS_EN
    , .flag_z(fz8), .flag_c(fc8), .flag_v(fv8)
`endif
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     mode;  // 0: random out_ready, 1: held high, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     rd;
    longint due;
    bit     z, c, v;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic int eff_n(int w, int s, int a);
    int n;
    n = a & ((1 << $clog2(w)) - 1);
    if (s == 5) return n % w;
    return (n > w - 1) ? w - 1 : n;
  endfunction

  function automatic int to_signed(int w, int x);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  function automatic int ref_rd(int w, int s, int a, int b);
    int mask, n;
    mask = (1 << w) - 1;
    n    = eff_n(w, s, a);
    case (s)
      0:       return (a - b) & mask;
      1:       return (a + b) & mask;
      2:       return a | b;
      3:       return a & b;
      4:       return (to_signed(w, b) >>> n) & mask;
      5:       return ((b << n) | (b >> (w - n))) & mask;
      6:       return (a < b) ? 1 : 0;
      default: return (a == b) ? 1 : 0;
    endcase
  endfunction

  function automatic int extra_lat(int w, int s, int a);
    return (s == 4 || s == 5) ? eff_n(w, s, a) : 0;
  endfunction

  function automatic exp_t make_exp(int w, int s, int a, int b, longint due);
    exp_t e;
    int   lo, hi, r;
    lo    = -(1 << (w - 1));
    hi    = (1 << (w - 1)) - 1;
    e.rd  = ref_rd(w, s, a, b);
    e.due = due;
    e.z   = (e.rd == 0);
    e.c   = 1'b0;
    e.v   = 1'b0;
    if (s == 1) begin
      e.c = (a + b) >= (1 << w);
      r   = to_signed(w, a) + to_signed(w, b);
      e.v = (r < lo) || (r > hi);
    end else if (s == 0) begin
      e.c = (a >= b);
      r   = to_signed(w, a) - to_signed(w, b);
      e.v = (r < lo) || (r > hi);
    end
    return e;
  endfunction

  // Present an op at posedge+1; returns at posedge+1 after the accept edge
  // with in_valid still high.
  task automatic issue(int s, int a, int b, bit track, output int waits);
    waits    = 0;
    in_valid = 1'b1;
    sel      = 3'(s);
    rs       = a[W-1:0];
    rt       = b[W-1:0];
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      waits++;
      if (waits > 100) begin
        chk("issue_timeout", 1, 0);
        break;
      end
    end
    if (track && waits <= 100)
      sb.push_back(make_exp(W, s, a, b, cyc + 1 + extra_lat(W, s, a)));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  bit           have_prev = 0, seen = 0;
  logic         prev_ov, prev_or;
  logic [W-1:0] prev_rd;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      have_prev = 0;
      seen      = 0;
    end else begin
      if (have_prev && prev_ov && !prev_or) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_rd", rd, prev_rd);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (busy) chk("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          if (!seen) begin
            chk("latency", cyc, sb[0].due);
            seen = 1;
          end
          if (out_ready) begin
            chk("rd", rd, sb[0].rd);
`ifdef DAE_FLAGS_EN
            chk("flag_z", flag_z, sb[0].z);
            chk("flag_c", flag_c, sb[0].c);
            chk("flag_v", flag_v, sb[0].v);
`endif
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
      prev_ov   = out_valid;
      prev_or   = out_ready;
      prev_rd   = rd;
      have_prev = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { int s, a, b; } op_t;
  op_t dir[8];
  int  waits;

  initial begin
    mode = 1;
    rst_n = 1'b0;
    in_valid = 1'b0; sel = '0; rs = '0; rt = '0;
    in_valid8 = 1'b0; sel8 = '0; rs8 = '0; rt8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rd", rd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rd8", rd8, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);

    // Directed stream: arithmetic, compares, then shifts, in_valid held.
    dir[0] = '{0, 3, 5};   dir[1] = '{1, 9, 9};
    dir[2] = '{6, 3, 5};   dir[3] = '{7, 10, 10};
    dir[4] = '{2, 5, 10};  dir[5] = '{4, 2, 8};
    dir[6] = '{5, 3, 9};   dir[7] = '{5, 0, 6};
    for (int i = 0; i < 8; i++) begin
      issue(dir[i].s, dir[i].a, dir[i].b, 1, waits);
      if (i >= 1 && i <= 5) chk("b2b_no_wait", waits, 0);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure for 5 cycles, then accept on the draining edge.
    issue(3, 12, 6, 1, waits);
    in_valid = 1'b0;
    mode = 2;
    repeat (5) @(posedge clk);
    #1;
    mode = 1;
    issue(1, 7, 8, 1, waits);
    chk("accept_on_drain", waits, 0);
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a 3-step rotate: nothing may come out.
    issue(5, 3, 9, 0, waits);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_rd", rd, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    issue(1, 2, 3, 1, waits);
    in_valid = 1'b0;
    drain();

    // Randomized traffic with random out_ready and input gaps.
    mode = 0;
    for (int i = 0; i < 300; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), 1, waits);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    mode = 1;
    drain();

    // WIDTH=8: full-range ASR and wrapping SUB.
    dir[0] = '{4, 7, 8'h80};
    dir[1] = '{0, 0, 1};
    for (int k = 0; k < 2; k++) begin
      longint t0;
      int     j;
      in_valid8 = 1'b1;
      sel8 = 3'(dir[k].s);
      rs8  = dir[k].a[7:0];
      rt8  = dir[k].b[7:0];
      @(negedge clk);
      chk("w8_in_ready", in_ready8, 1);
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      t0 = cyc;
      j = 0;
      while (j < 20) begin
        @(negedge clk);
        if (out_valid8 === 1'b1) break;
        j++;
      end
      chk("w8_found", (j < 20), 1);
      chk("w8_latency", cyc - t0, extra_lat(8, dir[k].s, dir[k].a));
      chk("w8_rd", rd8, ref_rd(8, dir[k].s, dir[k].a, dir[k].b));
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_execute_seq.md
Name: decode_execute_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational decode-and-execute ALU.
- Same 8-entry opcode map, generalised to WIDTH bits.
- Adds valid/ready handshakes on input and output, and a registered result.
- Shifts become variable-amount and multi-cycle, one bit position per clock, under a small FSM.
- Sits between the operand-fetch stage and the writeback stage of the lab datapath.

Parameters:
- WIDTH, 4: operand/result width in bits; legal 2..32.
- SHAMT_W, $clog2(WIDTH): width of the shift-amount field taken from rs; derived, do not override.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept this cycle
- rs  in  WIDTH  operand A; low SHAMT_W bits are the shift amount for sel 4/5
- rt  in  WIDTH  operand B; data shifted for sel 4/5
- sel  in  3  opcode
- out_valid  out  1  rd holds a result
- out_ready  in  1  downstream accepts rd
- rd  out  WIDTH  result
- busy  out  1  FSM in SHIFT state

Behaviour:
- Opcodes; all arithmetic is modulo 2^WIDTH:
  - 0: SUB, rs-rt (two's complement).
  - 1: ADD, rs+rt.
  - 2: OR, rs|rt.
  - 3: AND, rs&rt.
  - 4: ASR, rt arithmetic right shift by n=rs[SHAMT_W-1:0]; MSB replicated.
  - 5: ROL, rt rotate left by n.
  - 6: LT, unsigned rs<rt, result zero-extended to WIDTH.
  - 7: EQ, rs==rt, result zero-extended to WIDTH.
- Reset (async assert, sync deassert handled upstream):
  - out_valid=0, rd=0, busy=0, state=IDLE, internal counter=0.
  - in_ready=1 once rst_n is high.
- Handshake:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependence on in_valid.
  - While out_valid && !out_ready, rd and out_valid hold stable.
- FSM states: IDLE, SHIFT.
  - IDLE, accept with sel 0-3 or 6-7, or sel 4/5 with n==0: result (rt unchanged when n==0) written to rd, out_valid=1 at the next edge. Latency 1, throughput 1 per clock with out_ready high.
  - IDLE, accept with sel 4/5 and n>0: working reg<=rt, cnt<=n, op latched, go to SHIFT, busy=1.
  - SHIFT: each edge shifts working reg by one position and decrements cnt.
  - SHIFT, cnt==1: final shifted value goes to rd, out_valid=1, return to IDLE. Shift latency = n cycles from the accept edge.
  - SHIFT ignores in_valid; in_ready=0.
- Output register is free to load on the edge it is drained (simultaneous accept and drain allowed).
- n ranges 0..WIDTH-1. For non-power-of-2 WIDTH, ROL uses n mod WIDTH computed at accept; ASR saturates n at WIDTH-1.
- rst_n low mid-SHIFT: operation aborted immediately, no result produced.

Optional Feature:
- Macro DAE_FLAGS_EN.
- Defined: extra outputs flag_z, flag_c, flag_v (1 bit each) registered alongside rd and valid with out_valid.
  - z = (rd==0).
  - c = adder carry-out; SUB computed as rs+~rt+1, so c=1 means no borrow.
  - v = signed overflow for ADD/SUB.
  - c=v=0 for all other opcodes. All flags reset to 0.
- Undefined: ports absent, no flag logic.

Test Plan (WIDTH=4 unless noted):
- sel=0, rs=3, rt=5, out_ready=1 -> rd=4'hE one cycle after accept; flags z=0, c=0, v=0. sel=1, rs=9, rt=9 -> rd=4'h2, c=1, v=1.
- Back-to-back stream, in_valid held: sel=6 rs=3 rt=5 -> rd=1; sel=7 rs=A rt=A -> rd=1; sel=2 rs=5 rt=A -> rd=F. Results on consecutive cycles; in_ready stays 1.
- sel=4, rt=4'b1000, rs=2 -> busy and in_ready low for 2 cycles, then rd=4'b1110. sel=5, rt=4'b1001, rs=3 -> rd=4'b1100 after 3 cycles. sel=5, rs=0 -> rd=rt after 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after a result -> rd and out_valid stable, in_ready=0. On release, new op accepted the same edge the old result drains.
- rst_n pulsed low mid-SHIFT (rs=3, after 1 cycle) -> out_valid=0, rd=0, busy=0 asynchronously; no result ever emitted. Next op after release behaves normally.
- WIDTH=8: sel=4, rt=8'h80, rs=7 -> rd=8'hFF after 7 cycles. sel=0, rs=0, rt=1 -> rd=8'hFF.
